// File: rtl/max_min_seq_finder_pkg.sv
// ============================================================================
// Module : fmax_pkg
// Shared state encoding and mode constants for the max/min frame finder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fmax_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/max_min_seq_finder_ext_cmp.sv
// ============================================================================
// Module : ext_cmp
// Strict unsigned extreme compare: take_a when a beats b in the chosen mode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ext_cmp
  import fmax_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             take_a
);

  // Strict compare so that ties always keep the earlier sample.
  assign take_a = (mode == MODE_MIN) ? (a < b) : (a > b);

endmodule

`default_nettype wire

// File: rtl/max_min_seq_finder.sv
// ============================================================================
// Module : max_min_seq_finder
// Streams a COUNT-sample frame and reports its max/min value and first index.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module max_min_seq_finder
  import fmax_pkg::*;
#(
  parameter int  WIDTH = 4,
  parameter int  COUNT = 5,
  localparam int IDX_W = $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy
);

  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(COUNT - 1);
  localparam logic [IDX_W-1:0] C_ONE  = IDX_W'(1);

  state_t           r_state;
  logic             r_mode;
  logic [WIDTH-1:0] r_best;
  logic [IDX_W-1:0] r_best_idx;
  logic [IDX_W-1:0] r_cnt;

  state_t           w_state_nx;
  logic             w_mode_nx;
  logic [WIDTH-1:0] w_best_nx;
  logic [IDX_W-1:0] w_idx_nx;
  logic [IDX_W-1:0] w_cnt_nx;
  logic             w_take;

  ext_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a      (in_data),
    .b      (r_best),
    .mode   (r_mode),
    .take_a (w_take)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mode     <= MODE_MAX;
      r_best     <= '0;
      r_best_idx <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_mode     <= w_mode_nx;
      r_best     <= w_best_nx;
      r_best_idx <= w_idx_nx;
      r_cnt      <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_mode_nx  = r_mode;
    w_best_nx  = r_best;
    w_idx_nx   = r_best_idx;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_mode_nx  = mode;
          w_best_nx  = in_data;
          w_idx_nx   = '0;
          w_cnt_nx   = C_ONE;
          w_state_nx = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          if (w_take) begin
            w_best_nx = in_data;
            w_idx_nx  = r_cnt;
          end
          // Explicit terminal compare: COUNT need not be a power of two.
          if (r_cnt == C_LAST) begin
            w_cnt_nx   = '0;
            w_state_nx = S_DONE;
          end else begin
            w_cnt_nx = r_cnt + C_ONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state != S_DONE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_ACCUM);
  assign out_val   = r_best;
  assign out_idx   = r_best_idx;

endmodule

`default_nettype wire

// File: tb/tb_max_min_seq_finder.sv
// ============================================================================
// Module : tb_max_min_seq_finder
// Scoreboard bench for the default (4-bit x5) and a wide (8-bit x7) instance.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_max_min_seq_finder;

  typedef struct packed {
    logic [3:0] v;
    logic [2:0] i;
  } exp_t;

  typedef struct packed {
    logic [7:0] v;
    logic [2:0] i;
  } wexp_t;

  typedef logic [3:0] frame_t [5];
  typedef logic [7:0] wframe_t [7];

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_val;
  logic [2:0] out_idx;
  logic       busy;

  logic       wmode;
  logic       win_valid;
  logic       win_ready;
  logic [7:0] win_data;
  logic       wout_valid;
  logic       wout_ready;
  logic [7:0] wout_val;
  logic [2:0] wout_idx;
  logic       wbusy;

  int total = 0;
  int bad   = 0;

  exp_t  sb[$];
  wexp_t wsb[$];

  max_min_seq_finder #(.WIDTH(4), .COUNT(5)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .out_idx(out_idx), .busy(busy)
  );

  max_min_seq_finder #(.WIDTH(8), .COUNT(7)) dut_w (
    .clk(clk), .rst_n(rst_n), .mode(wmode), .in_valid(win_valid), .in_ready(win_ready),
    .in_data(win_data), .out_valid(wout_valid), .out_ready(wout_ready), .out_val(wout_val),
    .out_idx(wout_idx), .busy(wbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the sample was accepted.
  task automatic push_sample(input logic [3:0] s, input logic m);
    int n = 0;
    in_valid = 1'b1;
    in_data  = s;
    mode     = m;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input logic m, input int gap, input int flip_at,
                            input logic [3:0] ev, input logic [2:0] ei);
    sb.push_back('{v: ev, i: ei});
    for (int k = 0; k < 5; k++) begin
      push_sample(f[k], (k >= flip_at) ? ~m : m);
      if (gap > 0 && k < 4) begin
        repeat (gap) @(negedge clk);
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
          bad++;
          $display("FAIL stall_hold: busy=%b in_ready=%b out_valid=%b required 1/1/0", busy, in_ready, out_valid);
        end
      end
    end
  endtask

  task automatic get_result(input string name);
    exp_t e;
    int   n = 0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_latency: out_valid=%b required 1", name, out_valid);
    end
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_scoreboard: empty queue", name);
      return;
    end
    e = sb.pop_front();
    total++;
    if (out_val !== e.v) begin
      bad++;
      $display("FAIL %s_val: got=%0d required=%0d", name, out_val, e.v);
    end
    total++;
    if (out_idx !== e.i) begin
      bad++;
      $display("FAIL %s_idx: got=%0d required=%0d", name, out_idx, e.i);
    end
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_flags: busy=%b in_ready=%b required 0/0", name, busy, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    wmode = 1'b0; win_valid = 1'b0; win_data = '0; wout_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_val !== 4'd0 || out_idx !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b vld=%b val=%0d idx=%0d busy=%b required 1/0/0/0/0",
               in_ready, out_valid, out_val, out_idx, busy);
    end
    total++;
    if (win_ready !== 1'b1 || wout_valid !== 1'b0 || wout_val !== 8'd0 || wout_idx !== 3'd0 || wbusy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state_wide: rdy=%b vld=%b val=%0d idx=%0d busy=%b required 1/0/0/0/0",
               win_ready, wout_valid, wout_val, wout_idx, wbusy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_max_min();
    send_frame('{4'd3, 4'd9, 4'd2, 4'd9, 4'd1}, 1'b0, 0, 5, 4'd9, 3'd1);
    get_result("max_tie");
    send_frame('{4'd3, 4'd9, 4'd2, 4'd9, 4'd1}, 1'b1, 0, 5, 4'd1, 3'd4);
    get_result("min");
  endtask

  task automatic test_all_equal();
    send_frame('{4'd7, 4'd7, 4'd7, 4'd7, 4'd7}, 1'b0, 0, 5, 4'd7, 3'd0);
    get_result("eq_max");
    send_frame('{4'd7, 4'd7, 4'd7, 4'd7, 4'd7}, 1'b1, 0, 5, 4'd7, 3'd0);
    get_result("eq_min");
  endtask

  task automatic test_stall();
    send_frame('{4'd6, 4'd2, 4'd12, 4'd4, 4'd12}, 1'b0, 3, 5, 4'd12, 3'd2);
    get_result("stall");
  endtask

  task automatic test_backpressure();
    exp_t e;
    send_frame('{4'd4, 4'd8, 4'd8, 4'd2, 4'd6}, 1'b0, 0, 5, 4'd8, 3'd1);
    in_valid = 1'b1; in_data = 4'd15; mode = 1'b0;
    e = sb.pop_front();
    for (int c = 0; c < 10; c++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_val !== e.v || out_idx !== e.i) begin
        bad++;
        $display("FAIL bp_hold c%0d: rdy=%b vld=%b val=%0d idx=%0d required 0/1/%0d/%0d",
                 c, in_ready, out_valid, out_val, out_idx, e.v, e.i);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: vld=%b rdy=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
    end
    sb.push_back('{v: 4'd15, i: 3'd0});
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL bp_first_accept: busy=%b required 1", busy);
    end
    for (int k = 0; k < 4; k++) push_sample(4'd0, 1'b0);
    get_result("bp_next");
  endtask

  task automatic test_mode_flip();
    send_frame('{4'd1, 4'd5, 4'd3, 4'd4, 4'd2}, 1'b0, 0, 2, 4'd5, 3'd1);
    get_result("mode_flip");
  endtask

  task automatic test_mid_reset();
    push_sample(4'd9, 1'b0);
    push_sample(4'd1, 1'b0);
    push_sample(4'd4, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_val !== 4'd0) begin
      bad++;
      $display("FAIL mid_reset: vld=%b busy=%b rdy=%b val=%0d required 0/0/1/0", out_valid, busy, in_ready, out_val);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: vld=%b busy=%b required 0/0", out_valid, busy);
    end
    send_frame('{4'd0, 4'd0, 4'd0, 4'd0, 4'd6}, 1'b0, 0, 5, 4'd6, 3'd4);
    get_result("after_reset");
  endtask

  task automatic test_wide();
    wframe_t f;
    wexp_t   e;
    f = '{8'd10, 8'd200, 8'd255, 8'd3, 8'd255, 8'd0, 8'd1};
    wsb.push_back('{v: 8'd255, i: 3'd2});
    wmode = 1'b0;
    for (int k = 0; k < 7; k++) begin
      win_valid = 1'b1;
      win_data  = f[k];
      @(negedge clk);
    end
    win_valid = 1'b0;
    e = wsb.pop_front();
    total++;
    if (wout_valid !== 1'b1 || wout_val !== e.v || wout_idx !== e.i) begin
      bad++;
      $display("FAIL wide_result: vld=%b val=%0d idx=%0d required 1/%0d/%0d", wout_valid, wout_val, wout_idx, e.v, e.i);
    end
    wout_ready = 1'b1;
    @(negedge clk);
    wout_ready = 1'b0;
    total++;
    if (wout_valid !== 1'b0 || win_ready !== 1'b1) begin
      bad++;
      $display("FAIL wide_release: vld=%b rdy=%b required 0/1", wout_valid, win_ready);
    end
  endtask

  initial begin
    test_reset();
    test_max_min();
    test_all_equal();
    test_stall();
    test_backpressure();
    test_mode_flip();
    test_mid_reset();
    test_wide();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: entries=%0d required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
